// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture: detects RD commands, waits CAS latency, captures the
// burst into a show-ahead FIFO and hands words out over a valid/ready interface.
module sdram_rd_capture #(
  parameter int         CAS_LAT   = 3,
  parameter int         BURST_LEN = 4,
  parameter int         DATA_W    = 16,
  parameter int         FIFO_AW   = 4,
  parameter logic [3:0] RD_CMD    = 4'b0101
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic [3:0]        sdram_cmd,
  input  logic [DATA_W-1:0] rd_dq,
  input  logic              flush,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [FIFO_AW:0]  fifo_cnt,
  output logic              burst_done,
  output logic              overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BURST_LEN + 1);

  logic [CAS_LAT-1:0] r_cas_sr;
  logic [CW-1:0]      r_cap_cnt;
  logic               r_burst_done;
  logic               r_overflow;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;

  logic w_rd_hit;
  logic w_launch;
  logic w_cap_en;
  logic w_last_cap;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_rd_hit = (sdram_cmd == RD_CMD);
  assign w_launch = r_cas_sr[CAS_LAT-1];

  // A fresh launch restarts the burst, so only an uninterrupted countdown
  // reaching its final word may report completion.
  assign w_cap_en   = w_launch | (r_cap_cnt > CW'(1));
  assign w_last_cap = w_launch ? (BURST_LEN == 1) : (r_cap_cnt == CW'(2));

  assign w_full = (r_cnt == (FIFO_AW + 1)'(DEPTH));
  assign w_pop  = rd_valid & rd_ready;
  assign w_push = w_cap_en & (~w_full | w_pop);

  assign rd_valid   = (r_cnt != '0);
  assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_cnt   = r_cnt;
  assign burst_done = r_burst_done;
  assign overflow   = r_overflow;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (s_rst || flush) begin
      r_cas_sr     <= '0;
      r_cap_cnt    <= '0;
      r_burst_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
    end else begin
      r_cas_sr     <= {r_cas_sr[CAS_LAT-2:0], w_rd_hit};
      r_burst_done <= w_last_cap;

      if (w_launch)
        r_cap_cnt <= CW'(BURST_LEN);
      else if (r_cap_cnt != '0)
        r_cap_cnt <= r_cap_cnt - CW'(1);

      if (w_cap_en && w_full && !w_pop)
        r_overflow <= 1'b1;

      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (FIFO_AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (FIFO_AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; cleared pointers and count make
  // stale contents unreachable, and a reset would block RAM inference.
  always_ff @(posedge sclk) begin
    if (w_push && !flush && !s_rst)
      r_mem[r_wr_ptr] <= rd_dq;
  end

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Directed bench for sdram_rd_capture: per-cycle vector table plus hand-written
// fill / overflow / full-with-pop / reset sequences.
module tb_sdram_rd_capture;

  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] NOP = 4'b0111;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic [3:0]  sdram_cmd = NOP;
  logic [15:0] rd_dq = '0;
  logic        flush = 1'b0;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_cnt;
  logic        burst_done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_rd_capture dut (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .sdram_cmd  (sdram_cmd),
    .rd_dq      (rd_dq),
    .flush      (flush),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_cnt   (fifo_cnt),
    .burst_done (burst_done),
    .overflow   (overflow)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        rd;
    logic [15:0] dq;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    int          ec;
    logic        edone;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input logic rd, input logic [15:0] dq, input logic fl,
                              input logic rdy, input logic ev, input logic [15:0] ed,
                              input int ec, input logic edone);
    tbl.push_back('{rd, dq, fl, rdy, ev, ed, ec, edone});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic apply(input logic rd, input logic [15:0] dq, input logic fl,
                       input logic rdy, input logic rst);
    @(posedge sclk);
    #1;
    sdram_cmd = rd ? RD : NOP;
    rd_dq     = dq;
    flush     = fl;
    rd_ready  = rdy;
    s_rst     = rst;
    @(negedge sclk);
  endtask

  // Four back-to-back RDs spaced BURST_LEN apart, no draining: 16 words base+0..15.
  task automatic fill16(input logic [15:0] base, input string tag);
    for (int r = 0; r < 20; r++) begin
      int   e_cnt;
      logic e_done;
      apply((r % 4 == 0) && (r < 16),
            (r >= 3 && r <= 18) ? base + 16'(r - 3) : 16'hDEAD, 1'b0, 1'b0, 1'b0);
      e_cnt  = (r < 3) ? 0 : ((r - 3 > 16) ? 16 : r - 3);
      e_done = (r >= 7) && ((r - 7) % 4 == 0);
      check($sformatf("%s cnt r%0d", tag, r), 32'(fifo_cnt), 32'(e_cnt));
      check($sformatf("%s done r%0d", tag, r), 32'(burst_done), 32'(e_done));
    end
    check({tag, " ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    // Single RD, streaming out with rd_ready held high.
    row(1, 16'hDEAD, 0, 1,  0, 16'h0,  0, 0);
    row(0, 16'hDEAD, 0, 1,  0, 16'h0,  0, 0);
    row(0, 16'hDEAD, 0, 1,  0, 16'h0,  0, 0);
    row(0, 16'h00A0, 0, 1,  0, 16'h0,  0, 0);
    row(0, 16'h00A1, 0, 1,  1, 16'hA0, 1, 0);
    row(0, 16'h00A2, 0, 1,  1, 16'hA1, 1, 0);
    row(0, 16'h00A3, 0, 1,  1, 16'hA2, 1, 0);
    row(0, 16'hDEAD, 0, 1,  1, 16'hA3, 1, 1);
    row(0, 16'hDEAD, 0, 1,  0, 16'h0,  0, 0);
    // Overlapping RDs two cycles apart: 2 + 4 words, one done, then drain.
    row(1, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(1, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00B0, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00B1, 0, 0,  1, 16'hB0, 1, 0);
    row(0, 16'h00B2, 0, 0,  1, 16'hB0, 2, 0);
    row(0, 16'h00B3, 0, 0,  1, 16'hB0, 3, 0);
    row(0, 16'h00B4, 0, 0,  1, 16'hB0, 4, 0);
    row(0, 16'h00B5, 0, 0,  1, 16'hB0, 5, 0);
    row(0, 16'h0000, 0, 0,  1, 16'hB0, 6, 1);
    row(0, 16'h0000, 0, 1,  1, 16'hB0, 6, 0);
    row(0, 16'h0000, 0, 1,  1, 16'hB1, 5, 0);
    row(0, 16'h0000, 0, 1,  1, 16'hB2, 4, 0);
    row(0, 16'h0000, 0, 1,  1, 16'hB3, 3, 0);
    row(0, 16'h0000, 0, 1,  1, 16'hB4, 2, 0);
    row(0, 16'h0000, 0, 1,  1, 16'hB5, 1, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    // Flush mid-burst (with an RD in the flush cycle), then a normal RD.
    row(1, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00C0, 0, 0,  0, 16'h0,  0, 0);
    row(1, 16'h00C1, 1, 0,  1, 16'hC0, 1, 0);
    row(0, 16'h00C2, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00C3, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00C4, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(1, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h0000, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00D0, 0, 0,  0, 16'h0,  0, 0);
    row(0, 16'h00D1, 0, 0,  1, 16'hD0, 1, 0);
    row(0, 16'h00D2, 0, 0,  1, 16'hD0, 2, 0);
    row(0, 16'h00D3, 0, 0,  1, 16'hD0, 3, 0);
    row(0, 16'h0000, 0, 0,  1, 16'hD0, 4, 1);
    row(0, 16'h0000, 0, 0,  1, 16'hD0, 4, 0);

    // Reset state.
    for (int i = 0; i < 3; i++) apply(0, 16'h0, 0, 0, 1);
    check("rst data",  32'(rd_data),    32'd0);
    check("rst valid", 32'(rd_valid),   32'd0);
    check("rst cnt",   32'(fifo_cnt),   32'd0);
    check("rst done",  32'(burst_done), 32'd0);
    check("rst ovf",   32'(overflow),   32'd0);

    foreach (tbl[i]) begin
      apply(tbl[i].rd, tbl[i].dq, tbl[i].fl, tbl[i].rdy, 1'b0);
      check($sformatf("vec%0d valid", i), 32'(rd_valid),   32'(tbl[i].ev));
      check($sformatf("vec%0d cnt", i),   32'(fifo_cnt),   32'(tbl[i].ec));
      check($sformatf("vec%0d done", i),  32'(burst_done), 32'(tbl[i].edone));
      if (tbl[i].ev)
        check($sformatf("vec%0d data", i), 32'(rd_data), 32'(tbl[i].ed));
    end
    apply(0, 16'h0, 1, 0, 0);
    apply(0, 16'h0, 0, 0, 0);
    check("post-table flush cnt", 32'(fifo_cnt), 32'd0);

    // Fill, then overflow with one more burst, then drain the original 16.
    fill16(16'h1000, "fill1");
    for (int r = 0; r < 9; r++) begin
      apply(r == 0, (r >= 3 && r <= 6) ? 16'hEE00 + 16'(r) : 16'h0, 0, 0, 0);
      check($sformatf("ovf r%0d", r), 32'(overflow), 32'(r >= 4));
      check($sformatf("ovf cnt r%0d", r), 32'(fifo_cnt), 32'd16);
    end
    for (int k = 0; k < 16; k++) begin
      apply(0, 16'h0, 0, 1, 0);
      check($sformatf("drain1 data %0d", k), 32'(rd_data), 32'h1000 + 32'(k));
      check($sformatf("drain1 cnt %0d", k), 32'(fifo_cnt), 32'(16 - k));
      check($sformatf("drain1 ovf %0d", k), 32'(overflow), 32'd1);
    end
    apply(0, 16'h0, 0, 0, 0);
    check("drain1 empty valid", 32'(rd_valid), 32'd0);
    check("drain1 empty cnt",   32'(fifo_cnt), 32'd0);
    check("ovf sticky",         32'(overflow), 32'd1);
    apply(0, 16'h0, 1, 0, 0);
    apply(0, 16'h0, 0, 0, 0);
    check("ovf cleared by flush", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous pops during a new burst: nothing dropped.
    fill16(16'h2000, "fill2");
    for (int r = 0; r < 8; r++) begin
      apply(r == 0, (r >= 3 && r <= 6) ? 16'h00F0 + 16'(r - 3) : 16'hDEAD, 0,
            (r >= 3 && r <= 6), 0);
      check($sformatf("fullpop cnt r%0d", r), 32'(fifo_cnt), 32'd16);
      check($sformatf("fullpop ovf r%0d", r), 32'(overflow), 32'd0);
      if (r >= 3 && r <= 6)
        check($sformatf("fullpop head r%0d", r), 32'(rd_data), 32'h2000 + 32'(r - 3));
    end
    for (int k = 0; k < 16; k++) begin
      apply(0, 16'h0, 0, 1, 0);
      check($sformatf("drain2 data %0d", k), 32'(rd_data),
            (k < 12) ? 32'h2004 + 32'(k) : 32'h00F0 + 32'(k - 12));
    end
    apply(0, 16'h0, 0, 0, 0);
    check("drain2 empty valid", 32'(rd_valid), 32'd0);

    // Synchronous reset in the middle of a burst.
    for (int r = 0; r < 9; r++) begin
      apply(r == 0, (r >= 3 && r <= 6) ? 16'h0050 + 16'(r) : 16'h0, 0, 0, r == 4);
      if (r >= 5) begin
        check($sformatf("midrst cnt r%0d", r), 32'(fifo_cnt), 32'd0);
        check($sformatf("midrst done r%0d", r), 32'(burst_done), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
